dds_spi_responder: RTL and testbench
====================================

# dds_spi_responder

Synthesizable model of the DDS chip's serial control port, acting as the responder to our SPI register-write initiator. It accepts instruction/data frames on SCLK/CS/SDIO, holds a double-buffered register file (shadow and active), returns shadow contents on SDO for read instructions, and transfers shadow to active on IO_UPDATE. It is used for FPGA loopback and closed-loop simulation in place of the real DDS, so controller and UART command paths can be exercised without hardware.

## Interface
- ADDR_W, 5, register address width; the register file has 2^ADDR_W entries.
- DATA_W, 32, data word width; every register is DATA_W bits.
- clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  serial clock from the initiator, asynchronous to clk.
- CS  in  1  chip select, active low.
- SDIO  in  1  serial data into the responder, sampled on SCLK rising edges.
- SDO  out  1  serial read data, changed on SCLK falling edges.
- SYNCIO  in  1  active-high serial-port resync.
- IO_UPDATE  in  1  rising edge copies the shadow registers to the active registers.
- obs_addr  in  ADDR_W  observation address into the active registers.
- obs_data  out  DATA_W  active[obs_addr], registered.
- wr_strobe  out  1  one-clk pulse when a write commits to shadow.
- wr_addr  out  ADDR_W  address of the last committed write.
- wr_data  out  DATA_W  data of the last committed write.
- abort  out  1  one-clk pulse when CS deasserts or SYNCIO fires mid-frame.

## Operation
- Input conditioning: SCLK, CS, SYNCIO and IO_UPDATE each pass through a 2-flop synchronizer followed by an edge detector. SDIO is synchronized with the same depth so it stays aligned with SCLK.
- Frame format: an 8-bit instruction, MSB first, then a DATA_W-bit data word, MSB first.
  - Instruction bit 7 = 1 means read, 0 means write.
  - Bits 6:ADDR_W are ignored; bits ADDR_W-1:0 give the address.
- States: IDLE, INSTR, WDATA, RDATA.
  - IDLE → INSTR when CS is low (synchronized). The bit counter clears.
  - INSTR: shift SDIO on each SCLK rise. After the 8th rise, go to WDATA (write) or RDATA (read) and latch the address.
  - Read load: on entering RDATA, load the shift-out register with shadow[addr] and drive its MSB on SDO immediately.
  - WDATA: shift DATA_W bits. After the last rise, commit to shadow[addr], pulse wr_strobe, and update wr_addr/wr_data. Then return to INSTR.
  - RDATA: on each SCLK fall, shift out the next bit. After the DATA_W-th rise, return to INSTR.
- Multiple frames may be sent back to back within one CS-low window.
- CS high in any state → IDLE with the counter cleared. A partial word is discarded and shadow is unchanged.
  - If this happens while not in IDLE and the counter is nonzero, pulse abort.
- SYNCIO rise takes priority over SCLK. It returns the state to INSTR (CS low) or IDLE (CS high), clears the counter, and pulses abort if mid-frame.
- SDO is 0 outside RDATA.
- IO_UPDATE rise: active ← shadow for all entries in one clk.
  - If a write commit happens in the same clk, the committed word is included in the copy.

## Timing
- Reset values: every shadow and active entry is 0; SDO=0, wr_strobe=0, abort=0, wr_addr=0, wr_data=0, obs_data=0; state is IDLE.
- Latency from a pin edge to internal action is 3 clk (2 sync + 1 edge register).
- Required SCLK high and low times: each ≥ 4 clk periods. CS setup before the first SCLK rise: ≥ 4 clk.
- SDO changes 3–4 clk after the SCLK fall that triggers it.
- wr_strobe fires 1 clk after the detected final data rise. active reflects a write 1 clk after the detected IO_UPDATE rise.
- obs_data = active[obs_addr] with 1 clk latency.
- rst mid-frame: the frame is lost, all registers clear, and the responder waits in IDLE until CS is seen high then low again.

## Structure
- Package dds_spi_pkg: the state enum, INSTR_W=8, RW_BIT=7, and the default ADDR_W/DATA_W.
- Sub-module sync_edge (2-flop synchronizer plus rise/fall detect, reset to 0). It is instantiated for SCLK, CS, SYNCIO and IO_UPDATE; for CS, the synchronizer flops reset to 1 so CS reads as deasserted after reset.
- The register file is flop-based so the whole-array copy takes one clk.

## Test plan
- Write 0x01 with 0xDEADBEEF → wr_strobe pulses and obs_data at 0x01 reads 0 until IO_UPDATE. After IO_UPDATE, obs_data = 0xDEADBEEF.
- Write 0x05 with 0x12345678, then read (instruction 0x85) in the same CS window → SDO yields 0x12345678 MSB first, sampled on SCLK rises.
- Write to 0x02, with CS raised after 20 data bits → abort pulses, shadow[0x02] stays 0, and the next full frame works.
- SYNCIO pulse after 5 instruction bits, then a full write of 0x03 with 0xA5A5A5A5 → abort pulses and shadow[0x03] = 0xA5A5A5A5.
- Final data bit and IO_UPDATE rise detected in the same clk → active contains the new word.
- rst asserted mid-read → SDO=0, all registers are 0, and the responder stays in IDLE until CS toggles.

Source files
------------

// File: rtl/dds_spi_pkg.sv
// Shared types and constants for the DDS serial-port responder model.
package dds_spi_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned RW_BIT     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

endpackage

// File: rtl/dds_spi_responder_sync_edge.sv
// Two-flop synchronizer with a third edge register; rise/fall are combinational from the last two stages.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= RST_VAL;
      level <= RST_VAL;
      prev  <= RST_VAL;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/dds_spi_responder.sv
// SPI responder standing in for the DDS control port: shadow/active register file,
// serial writes and reads, IO_UPDATE transfer, and commit/abort observation outputs.
module dds_spi_responder
  import dds_spi_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              SDIO,
  output logic              SDO,
  input  logic              SYNCIO,
  input  logic              IO_UPDATE,
  input  logic [ADDR_W-1:0] obs_addr,
  output logic [DATA_W-1:0] obs_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              abort
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sync_lvl, sync_rise, sync_fall;
  logic upd_lvl, upd_rise, upd_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(SCLK), .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(CS), .level(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_syncio (
    .clk(clk), .rst(rst), .din(SYNCIO), .level(sync_lvl), .rise_c(sync_rise), .fall_c(sync_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_io_update (
    .clk(clk), .rst(rst), .din(IO_UPDATE), .level(upd_lvl), .rise_c(upd_rise), .fall_c(upd_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, cs_rise, cs_fall, sync_lvl, sync_fall, upd_lvl, upd_fall};

  // SDIO gets the same depth as SCLK so the sampled bit lines up with the detected rise.
  logic       sdio_meta, sdio_sync;
  logic [1:0] cs_fill;
  logic       armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sdio_meta <= 1'b0;
      sdio_sync <= 1'b0;
      cs_fill   <= '0;
      armed     <= 1'b0;
    end else begin
      sdio_meta <= SDIO;
      sdio_sync <= sdio_meta;
      cs_fill   <= {cs_fill[0], 1'b1};
      if (cs_fill[1] && cs_lvl) armed <= 1'b1;
    end
  end

  // After reset, frames are accepted only once CS has genuinely been observed high.
  logic cs_sel;
  assign cs_sel = armed & ~cs_lvl;

  logic [DATA_W-1:0] shadow [NREG];
  logic [DATA_W-1:0] active [NREG];

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] sin, sin_nxt;
  logic [DATA_W-1:0] sout, sout_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              sdo_nxt, abort_nxt, commit, mid_frame;
  logic [DATA_W-1:0] word;

  assign mid_frame = (state != IDLE) && (cnt != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sin_nxt   = sin;
    sout_nxt  = sout;
    addr_nxt  = addr;
    sdo_nxt   = SDO;
    abort_nxt = 1'b0;
    commit    = 1'b0;
    word      = {sin[DATA_W-2:0], sdio_sync};
    if (!cs_sel) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      abort_nxt = mid_frame;
    end else if (sync_rise) begin
      state_nxt = INSTR;
      cnt_nxt   = '0;
      abort_nxt = mid_frame;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = INSTR;
          cnt_nxt   = '0;
        end
        INSTR: if (sclk_rise) begin
          sin_nxt = word;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(INSTR_W - 1)) begin
            cnt_nxt  = '0;
            addr_nxt = word[ADDR_W-1:0];
            if (word[RW_BIT]) begin
              state_nxt = RDATA;
              sout_nxt  = shadow[word[ADDR_W-1:0]];
              sdo_nxt   = shadow[word[ADDR_W-1:0]][DATA_W-1];
            end else begin
              state_nxt = WDATA;
            end
          end
        end
        WDATA: if (sclk_rise) begin
          sin_nxt = word;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            commit    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = INSTR;
          end
        end
        RDATA: begin
          // The fall right after the instruction must not shift: the MSB is still owed.
          if (sclk_rise) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              cnt_nxt   = '0;
              state_nxt = INSTR;
            end
          end else if (sclk_fall && cnt != '0) begin
            sout_nxt = sout << 1;
            sdo_nxt  = sout[DATA_W-2];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (state_nxt != RDATA) sdo_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sin       <= '0;
      sout      <= '0;
      addr      <= '0;
      SDO       <= 1'b0;
      abort     <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sin       <= sin_nxt;
      sout      <= sout_nxt;
      addr      <= addr_nxt;
      SDO       <= sdo_nxt;
      abort     <= abort_nxt;
      wr_strobe <= commit;
      if (commit) begin
        wr_addr <= addr;
        wr_data <= word;
      end
    end
  end

  // A commit landing in the same clk as IO_UPDATE is forwarded into the active copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      obs_data <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (commit && addr == ADDR_W'(i)) shadow[i] <= word;
        if (upd_rise) active[i] <= (commit && addr == ADDR_W'(i)) ? word : shadow[i];
      end
      obs_data <= active[obs_addr];
    end
  end

endmodule

// File: tb/tb_dds_spi_responder.sv
// Bench for dds_spi_responder: directed frame scenarios plus random traffic against a register-file model.
`timescale 1ns/1ps
module tb_dds_spi_responder;
  localparam int NREG = 32;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst, SCLK, CS, SDIO, SYNCIO, IO_UPDATE;
  logic [4:0]  obs_addr;
  logic        SDO, wr_strobe, abort;
  logic [31:0] obs_data, wr_data;
  logic [4:0]  wr_addr;

  always #5 clk = ~clk;

  dds_spi_responder #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .SDIO(SDIO), .SDO(SDO),
    .SYNCIO(SYNCIO), .IO_UPDATE(IO_UPDATE), .obs_addr(obs_addr), .obs_data(obs_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .abort(abort)
  );

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int abort_cnt = 0;
  int sdo_high_idle = 0;
  logic [31:0] m_shadow [NREG];
  logic [31:0] m_active [NREG];

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) strobe_cnt++;
      if (abort) abort_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic sampled);
    SDIO = b;
    wait_clk(HALF);
    sampled = SDO;
    SCLK = 1'b1;
    wait_clk(HALF);
    SCLK = 1'b0;
  endtask

  task automatic send_bits(input logic [39:0] bits, input int n, output logic [31:0] rd);
    logic s;
    rd = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(bits[39-i], s);
      if (i >= 8) rd = {rd[30:0], s};
    end
  endtask

  task automatic cs_low();
    CS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    CS = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic write_frame(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic [1:0]  junk;
    junk = 2'($urandom);
    send_bits({1'b0, junk, a, d}, 40, rd);
    m_shadow[a] = d;
  endtask

  task automatic read_frame(input logic [4:0] a, input string tag);
    logic [31:0] rd;
    logic [1:0]  junk;
    junk = 2'($urandom);
    send_bits({1'b1, junk, a, 32'($urandom)}, 40, rd);
    check(tag, rd, m_shadow[a]);
  endtask

  task automatic io_update();
    IO_UPDATE = 1'b1;
    wait_clk(HALF);
    IO_UPDATE = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
  endtask

  task automatic obs_check(input logic [4:0] a, input string tag);
    obs_addr = a;
    wait_clk(2);
    check(tag, obs_data, m_active[a]);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    for (int i = 0; i < NREG; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  endtask

  initial begin
    int s0, a0;
    logic [31:0] d, rd;
    logic [39:0] fr;
    logic [4:0]  a;
    rst = 1'b1; SCLK = 1'b0; CS = 1'b1; SDIO = 1'b0; SYNCIO = 1'b0; IO_UPDATE = 1'b0;
    obs_addr = '0;
    apply_reset();

    check("rst_sdo", 32'(SDO), 32'h0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_abort", 32'(abort), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    obs_check(5'h1f, "rst_obs");

    // Write 0x01, visible on obs only after IO_UPDATE
    s0 = strobe_cnt;
    cs_low(); write_frame(5'h01, 32'hDEADBEEF); cs_high();
    check("w1_strobe", 32'(strobe_cnt - s0), 32'd1);
    check("w1_wr_addr", 32'(wr_addr), 32'h01);
    check("w1_wr_data", wr_data, 32'hDEADBEEF);
    obs_check(5'h01, "w1_obs_before");
    io_update();
    obs_check(5'h01, "w1_obs_after");

    // Write then read back in one CS window
    cs_low(); write_frame(5'h05, 32'h12345678); read_frame(5'h05, "rd_0x05"); cs_high();
    check("sdo_idle", 32'(SDO), 32'h0);

    // CS raised after 20 data bits
    s0 = strobe_cnt; a0 = abort_cnt;
    cs_low(); send_bits({8'h02, 32'hCAFEF00D}, 28, rd); cs_high();
    check("cs_abort_pulse", 32'(abort_cnt - a0), 32'd1);
    check("cs_abort_nowrite", 32'(strobe_cnt - s0), 32'd0);
    cs_low(); read_frame(5'h02, "cs_abort_shadow"); write_frame(5'h02, 32'h0BADF00D);
    read_frame(5'h02, "cs_abort_recover"); cs_high();

    // SYNCIO mid-instruction, then a full write in the same window
    a0 = abort_cnt;
    cs_low(); send_bits({8'h03, 32'h0}, 5, rd);
    SYNCIO = 1'b1; wait_clk(HALF); SYNCIO = 1'b0; wait_clk(HALF);
    write_frame(5'h03, 32'hA5A5A5A5); cs_high();
    check("sync_abort_pulse", 32'(abort_cnt - a0), 32'd1);
    cs_low(); read_frame(5'h03, "sync_shadow"); cs_high();

    // Final data rise and IO_UPDATE rise arrive together
    d = $urandom | 32'h1;
    fr = {8'h07, d};
    cs_low(); send_bits(fr, 39, rd);
    SDIO = fr[0]; wait_clk(HALF);
    IO_UPDATE = 1'b1; SCLK = 1'b1; wait_clk(HALF);
    SCLK = 1'b0; IO_UPDATE = 1'b0; cs_high();
    m_shadow[7] = d;
    for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
    obs_check(5'h07, "same_clk_update");
    obs_check(5'h01, "same_clk_other");

    // Random traffic
    for (int t = 0; t < 24; t++) begin
      int op;
      op = int'($urandom_range(0, 3));
      a = 5'($urandom);
      case (op)
        0: begin
          s0 = strobe_cnt;
          d = $urandom;
          cs_low(); write_frame(a, d);
          if ($urandom_range(0, 1) == 1) read_frame(a, "rnd_wr_rd");
          cs_high();
          check("rnd_strobe", 32'(strobe_cnt - s0), 32'd1);
          check("rnd_wr_data", wr_data, d);
        end
        1: begin cs_low(); read_frame(a, "rnd_rd"); cs_high(); end
        2: io_update();
        default: obs_check(a, "rnd_obs");
      endcase
    end

    // Reset in the middle of a read
    cs_low(); send_bits({8'h81, 32'h0}, 20, rd);
    apply_reset();
    check("midrst_sdo", 32'(SDO), 32'h0);
    check("midrst_wr_addr", 32'(wr_addr), 32'h0);
    check("midrst_wr_data", wr_data, 32'h0);
    obs_check(5'h01, "midrst_obs1");
    obs_check(5'h07, "midrst_obs7");
    s0 = strobe_cnt; a0 = abort_cnt;
    fork
      send_bits({8'h09, 32'h13579BDF}, 40, rd);
      repeat (40 * 2 * HALF) begin
        @(negedge clk);
        if (SDO) sdo_high_idle++;
      end
    join
    check("midrst_no_write", 32'(strobe_cnt - s0), 32'd0);
    check("midrst_no_abort", 32'(abort_cnt - a0), 32'd0);
    check("midrst_sdo_quiet", 32'(sdo_high_idle), 32'd0);
    cs_high();
    cs_low(); read_frame(5'h09, "midrst_shadow9"); write_frame(5'h09, 32'h2468ACE0);
    read_frame(5'h09, "midrst_recover"); cs_high();
    io_update();
    obs_check(5'h09, "midrst_obs9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
